// File: rtl/swept_pulse_mask.sv
// Swept-period pulse-mask generator. Emits gating pulses whose period steps linearly
// from a start to a stop period, in single, sawtooth-repeat or triangle mode.
module swept_pulse_mask #(
    parameter int                        DATA_W  = 16,
    parameter int                        CNT_W   = 32,
    parameter logic signed [DATA_W-1:0]  MASK_HI = {1'b0, {(DATA_W-1){1'b1}}}
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic                     i_trig,
    input  logic [1:0]               i_mode,
    input  logic [CNT_W-1:0]         i_period_start,
    input  logic [CNT_W-1:0]         i_period_stop,
    input  logic [CNT_W-1:0]         i_period_step,
    input  logic [CNT_W-1:0]         i_high_count,
    input  logic signed [DATA_W-1:0] i_passthrough,
    output logic signed [DATA_W-1:0] o_final_out,
    output logic signed [DATA_W-1:0] o_mask_dac,
    output logic                     o_busy,
    output logic                     o_sweep_done
);

    typedef enum logic { S_IDLE, S_RUN } state_t;
    typedef enum logic [1:0] {
        M_SINGLE     = 2'd0,
        M_SAWTOOTH   = 2'd1,
        M_TRIANGLE   = 2'd2,
        M_SINGLE_ALT = 2'd3
    } mode_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    state_t             r_state;
    mode_t              r_mode;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   r_start;
    logic [CNT_W-1:0]   r_stop;
    logic [CNT_W-1:0]   r_step;
    logic [CNT_W-1:0]   r_high;
    logic               r_dir_up;
    logic               r_trig_s;
    logic               r_trig_d;

    state_t             w_state_nx;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic [CNT_W-1:0]   w_period_nx;
    logic [CNT_W-1:0]   w_start_nx;
    logic [CNT_W-1:0]   w_stop_nx;
    logic               w_dir_up_nx;
    logic               w_load;
    logic               w_mask;
    logic               w_done;

    logic               w_start_ok;
    logic [CNT_W-1:0]   w_h_eff;
    logic               w_last;
    logic               w_at_stop;
    logic [CNT_W:0]     w_up_sum;
    logic [CNT_W:0]     w_dn_diff;
    logic [CNT_W-1:0]   w_up_next;
    logic [CNT_W-1:0]   w_dn_next;
    logic [CNT_W-1:0]   w_turn_up;
    logic [CNT_W-1:0]   w_turn_dn;

    assign w_start_ok = i_enable && r_trig_s && !r_trig_d
                        && (i_period_start >= TWO) && (i_period_stop >= TWO)
                        && (i_high_count != '0);

    assign w_h_eff   = (r_high < r_period) ? r_high : (r_period - ONE);
    assign w_last    = (r_cnt == (r_period - ONE));
    assign w_at_stop = (r_period == r_stop);

    // One extra bit so a step past either rail is caught and clamped, not wrapped.
    assign w_up_sum  = {1'b0, r_period} + {1'b0, r_step};
    assign w_dn_diff = {1'b0, r_period} - {1'b0, r_step};

    assign w_up_next = (w_up_sum >= {1'b0, r_stop}) ? r_stop : w_up_sum[CNT_W-1:0];
    assign w_dn_next = (w_dn_diff[CNT_W] || (w_dn_diff[CNT_W-1:0] <= r_stop))
                       ? r_stop : w_dn_diff[CNT_W-1:0];

    // Triangle turnaround: the old start becomes the new stop.
    assign w_turn_up = (w_up_sum >= {1'b0, r_start}) ? r_start : w_up_sum[CNT_W-1:0];
    assign w_turn_dn = (w_dn_diff[CNT_W] || (w_dn_diff[CNT_W-1:0] <= r_start))
                       ? r_start : w_dn_diff[CNT_W-1:0];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_period_nx = r_period;
        w_start_nx  = r_start;
        w_stop_nx   = r_stop;
        w_dir_up_nx = r_dir_up;
        w_load      = 1'b0;
        w_mask      = 1'b0;
        w_done      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                if (w_start_ok) begin
                    w_load      = 1'b1;
                    w_state_nx  = S_RUN;
                    w_period_nx = i_period_start;
                    w_start_nx  = i_period_start;
                    w_stop_nx   = i_period_stop;
                    w_dir_up_nx = (i_period_start <= i_period_stop);
                end
            end
            S_RUN: begin
                if (!i_enable) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_mask = (r_cnt < w_h_eff);
                    if (!w_last) begin
                        w_cnt_nx = r_cnt + ONE;
                    end else begin
                        w_cnt_nx = '0;
                        if (!w_at_stop) begin
                            w_period_nx = r_dir_up ? w_up_next : w_dn_next;
                        end else begin
                            w_done = 1'b1;
                            case (r_mode)
                                M_SAWTOOTH: w_period_nx = r_start;
                                M_TRIANGLE: begin
                                    w_start_nx  = r_stop;
                                    w_stop_nx   = r_start;
                                    w_dir_up_nx = !r_dir_up;
                                    w_period_nx = r_dir_up ? w_turn_dn : w_turn_up;
                                end
                                default:    w_state_nx = S_IDLE;
                            endcase
                        end
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_period <= '0;
            r_start  <= '0;
            r_stop   <= '0;
            r_dir_up <= 1'b1;
            r_step   <= '0;
            r_high   <= '0;
            r_mode   <= M_SINGLE;
            r_trig_s <= 1'b0;
            r_trig_d <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_period <= w_period_nx;
            r_start  <= w_start_nx;
            r_stop   <= w_stop_nx;
            r_dir_up <= w_dir_up_nx;
            r_trig_s <= i_trig;
            r_trig_d <= r_trig_s;
            if (w_load) begin
                r_step <= (i_period_step == '0) ? ONE : i_period_step;
                r_high <= i_high_count;
                r_mode <= mode_t'(i_mode);
            end
        end
    end

    // Registered outputs: one cycle behind the counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_final_out  <= '0;
            o_mask_dac   <= '0;
            o_sweep_done <= 1'b0;
        end else begin
            o_final_out  <= w_mask ? i_passthrough : '0;
            o_mask_dac   <= w_mask ? MASK_HI : '0;
            o_sweep_done <= w_done;
        end
    end

    assign o_busy = (r_state == S_RUN);

endmodule

// File: tb/tb_swept_pulse_mask.sv
// Directed, table-driven bench for swept_pulse_mask: sweep traces, gating, abort and reset.
module tb_swept_pulse_mask;

    localparam int CW = 32;
    localparam int DW = 16;

    logic                  clk = 1'b0;
    logic                  i_reset;
    logic                  i_enable;
    logic                  i_trig;
    logic [1:0]            i_mode;
    logic [CW-1:0]         i_period_start;
    logic [CW-1:0]         i_period_stop;
    logic [CW-1:0]         i_period_step;
    logic [CW-1:0]         i_high_count;
    logic signed [DW-1:0]  i_passthrough;
    logic signed [DW-1:0]  o_final_out;
    logic signed [DW-1:0]  o_mask_dac;
    logic                  o_busy;
    logic                  o_sweep_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    swept_pulse_mask dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_trig         (i_trig),
        .i_mode         (i_mode),
        .i_period_start (i_period_start),
        .i_period_stop  (i_period_stop),
        .i_period_step  (i_period_step),
        .i_high_count   (i_high_count),
        .i_passthrough  (i_passthrough),
        .o_final_out    (o_final_out),
        .o_mask_dac     (o_mask_dac),
        .o_busy         (o_busy),
        .o_sweep_done   (o_sweep_done)
    );

    typedef struct packed {
        int              start;
        int              stop;
        int              step;
        int              high;
        int              mode;
        int              pass;
        int              n;
        logic [6:0][7:0] per;
        logic [7:0]      done_bits;
        logic            retrig;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(int s, int e, int st, int h, int m, int pass, int n,
                                int p0, int p1, int p2, int p3, int p4, int p5, int p6,
                                int db, bit rt);
        vec_t v;
        v.start = s;  v.stop = e;  v.step = st;  v.high = h;
        v.mode  = m;  v.pass = pass;  v.n = n;
        v.per[0] = 8'(p0);  v.per[1] = 8'(p1);  v.per[2] = 8'(p2);  v.per[3] = 8'(p3);
        v.per[4] = 8'(p4);  v.per[5] = 8'(p5);  v.per[6] = 8'(p6);
        v.done_bits = 8'(db);
        v.retrig = rt;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {30'd0, o_busy, o_sweep_done, o_mask_dac, o_final_out};
    endfunction

    task automatic load_cfg(input int s, input int e, input int st, input int h, input int m);
        i_period_start = CW'(s);
        i_period_stop  = CW'(e);
        i_period_step  = CW'(st);
        i_high_count   = CW'(h);
        i_mode         = 2'(m);
    endtask

    // Launch from idle: trig sampled at edge t, busy after t+1.
    task automatic launch(input string tag);
        i_enable = 1'b1;
        i_trig   = 1'b0;
        tick;
        tick;
        i_trig = 1'b1;
        tick;
        check({tag, " busy_before_t1"}, {63'd0, o_busy}, 64'd0);
        i_trig = 1'b0;
        tick;
        check({tag, " busy_t1"}, {62'd0, o_busy, o_mask_dac[DW-1]}, 64'd2);
    endtask

    task automatic run_sweep(input vec_t v, input string tag);
        int total;
        int k;
        int per;
        int heff;
        bit single;
        logic signed [DW-1:0] pv;
        logic [63:0] exp_w;
        logic eb, ed, hi;

        single = (v.mode == 0) || (v.mode == 3);
        total = 0;
        for (int p = 0; p < v.n; p++) total += int'(v.per[p]);

        load_cfg(v.start, v.stop, v.step, v.high, v.mode);
        i_passthrough = DW'(v.pass);
        launch(tag);
        // Config changes after launch must not affect the running sweep.
        load_cfg(3, 40, 5, 1, single ? 1 : 0);

        k = 0;
        for (int p = 0; p < v.n; p++) begin
            per  = int'(v.per[p]);
            heff = (v.high < per) ? v.high : per - 1;
            for (int c = 0; c < per; c++) begin
                pv = DW'(v.pass + k * 37);
                i_passthrough = pv;
                if (v.retrig && k == 5) i_trig = 1'b1;
                if (v.retrig && k == 6) i_trig = 1'b0;
                tick;
                eb = single ? (k < total - 1) : 1'b1;
                ed = v.done_bits[p] && (c == per - 1);
                hi = (c < heff);
                exp_w = {30'd0, eb, ed, (hi ? 16'sh7FFF : 16'sh0), (hi ? pv : 16'sh0)};
                check($sformatf("%s pulse=%0d cyc=%0d", tag, p, c), outs(), exp_w);
                k++;
            end
        end

        if (single) begin
            tick;
            check({tag, " idle_after"}, outs(), 64'd0);
        end else begin
            i_enable = 1'b0;
            tick;
            check({tag, " abort_no_done"}, {63'd0, o_sweep_done}, 64'd0);
            tick;
            check({tag, " abort_zero"}, outs(), 64'd0);
        end
    endtask

    initial begin
        int dones;

        // start stop step H mode pass n periods... done_bits retrig
        vecs[0] = mk(10, 14, 2, 3, 0, -1234, 3, 10, 12, 14, 0, 0, 0, 0, 'b100, 1'b0);
        vecs[1] = mk(10, 13, 2, 3, 0,   500, 3, 10, 12, 13, 0, 0, 0, 0, 'b100, 1'b1);
        vecs[2] = mk( 8,  4, 4, 2, 3,  -77, 2,  8,  4,  0, 0, 0, 0, 0, 'b10, 1'b0);
        vecs[3] = mk( 4,  4, 0, 9, 0,  321, 1,  4,  0,  0, 0, 0, 0, 0, 'b1, 1'b0);
        vecs[4] = mk( 5,  7, 0, 2, 0,   99, 3,  5,  6,  7, 0, 0, 0, 0, 'b100, 1'b0);
        vecs[5] = mk( 6, 10, 2, 2, 2,  -42, 7,  6,  8, 10, 8, 6, 8, 10, 'b1010100, 1'b0);
        vecs[6] = mk( 6, 10, 2, 1, 1, 1000, 6,  6,  8, 10, 6, 8, 10, 0, 'b100100, 1'b0);

        i_reset = 1'b1;
        i_enable = 1'b0;
        i_trig = 1'b0;
        i_passthrough = 16'sd55;
        load_cfg(10, 14, 2, 3, 0);
        tick;
        tick;
        tick;
        check("reset_state", outs(), 64'd0);
        i_reset = 1'b0;
        tick;

        for (int i = 0; i < 7; i++) run_sweep(vecs[i], $sformatf("vec%0d", i));

        // Invalid HighCount=0 and invalid PeriodStart=1 ignore the trigger.
        load_cfg(10, 14, 2, 0, 0);
        i_enable = 1'b1;
        i_trig = 1'b1;
        tick;
        i_trig = 1'b0;
        tick;
        tick;
        tick;
        check("invalid_high0", outs(), 64'd0);
        load_cfg(1, 14, 2, 3, 0);
        i_trig = 1'b1;
        tick;
        i_trig = 1'b0;
        tick;
        tick;
        tick;
        check("invalid_start1", outs(), 64'd0);

        // Enable dropped mid-pulse.
        load_cfg(10, 14, 2, 3, 0);
        i_passthrough = 16'sd7;
        launch("abort");
        tick;
        tick;
        check("abort_high_before", outs(), {30'd0, 1'b1, 1'b0, 16'sh7FFF, 16'sd7});
        i_enable = 1'b0;
        tick;
        tick;
        check("abort_outputs_zero", outs(), 64'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (o_sweep_done || o_busy) dones++;
        end
        check("abort_stays_idle", 64'(dones), 64'd0);

        // Reset mid-sweep, then a fresh trigger restarts from PeriodStart.
        load_cfg(10, 14, 2, 3, 0);
        launch("rst");
        for (int i = 0; i < 4; i++) tick;
        i_reset = 1'b1;
        tick;
        check("reset_mid_sweep", outs(), 64'd0);
        i_reset = 1'b0;
        run_sweep(vecs[0], "after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
